usd_spi_multi: RTL and testbench
================================

// Module: usd_spi_multi
// PURPOSE
//   Z80 I/O-mapped SPI master for SD/MMC cards with NCS independent chip selects.
//   Adds over the single-card interface: programmable SCK divider, busy status port, sync reset.
//   The SPI shifter is internal; no external clock-enable is needed for the SPI side.
//   Sits on the CPU I/O bus beside the other port-decoded peripherals; pins go to the card slots.
// PARAMETERS
//   NCS       2      number of active-low chip-select outputs (1..8)
//   PORT_CS   8'hE7  chip-select port (write only)
//   PORT_DATA 8'hEB  data port: write = send byte; read = return last rx byte, then start an 0xFF exchange
//   PORT_STAT 8'hEF  status/divider port: read = status, write = divider
//   DIV_RST   8'd3   divider value after reset (SCK half-period = DIV+1 clocks)
// PORTS
//   clock  in   1    system clock
//   reset  in   1    synchronous active-high reset
//   cep    in   1    CPU bus clock-enable; bus strobes are sampled only when cep=1
//   iorq   in   1    active-low I/O request
//   wr     in   1    active-low write strobe
//   rd     in   1    active-low read strobe
//   a      in   8    low I/O address byte
//   d      in   8    CPU write data
//   q      out  8    CPU read data (combinational mux)
//   busy   out  1    1 while a transfer is in progress
//   cs     out  NCS  active-low card selects
//   ck     out  1    SPI SCK, mode 0 (idle low)
//   miso   in   1    SPI data from card
//   mosi   out  1    SPI data to card
// BEHAVIOUR
//   Reset (sync, reset=1 at posedge clock): cs=all 1, ck=0, busy=0, sr=8'hFF (mosi=1),
//     rxbuf=8'hFF, div=DIV_RST, edge-detect flops cleared. Reset mid-transfer aborts it at once.
//   Bus decode (on cep=1 only):
//     - iowr = !iorq && !wr; iord = !iorq && !rd.
//     - Each strobe is rising-edge detected against its previous-cep value; one-cycle start pulse.
//     - Write PORT_CS: cs <= d[NCS-1:0] (level action, every cep while asserted).
//     - Write PORT_STAT: div <= d (applies at next counter reload).
//   Starting a transfer:
//     - Edge of write PORT_DATA starts with tx byte = d.
//     - Edge of read PORT_DATA starts with tx byte = 8'hFF.
//     - Either start is ignored if busy=1: sr and rxbuf are unchanged, the read still returns rxbuf.
//   q mux: a==PORT_STAT -> {busy,7'b0}; otherwise rxbuf.
//     Read of PORT_DATA returns the byte of the previous exchange.
//   States: IDLE (busy=0) and XFER (busy=1).
//     - Start: sr<=tx byte, cnt<=div, bitcnt<=0, ck<=0, busy<=1.
//     - XFER, cnt!=0: cnt<=cnt-1.
//     - XFER, cnt==0 (tick): cnt<=div.
//       * ck==0: ck<=1, rbit<=miso (sample on rising SCK).
//       * ck==1: ck<=0, sr<={sr[6:0],rbit}, bitcnt<=bitcnt+1.
//         If bitcnt==7: rxbuf<={sr[6:0],rbit}, busy<=0 -> IDLE.
//   mosi = sr[7] at all times; MSB first; valid before the first rising SCK.
//   Latency: start pulse -> busy falls exactly 16*(div+1) clocks later.
//     div=0 gives SCK = clock/2; div=255 gives clock/512.
//   cs writes during XFER take effect immediately (software responsibility).
//   A div write during XFER changes the half-period from the next reload on.
// TESTING
//   1 Reset: after reset, cs=2'b11, ck=0, mosi=1, busy=0, status read=8'h00, data read=8'hFF.
//   2 div=0; write 8'hA5 to 8'hEB with miso looped to mosi -> 8 SCK pulses, mosi bits 1,0,1,0,0,1,0,1;
//     busy high 16 clocks; next data read returns 8'hA5.
//   3 div=3; read 8'hEB with miso driven per bit as 8'h3C -> mosi held 1, SCK half-period 4 clocks,
//     busy 64 clocks; read returns the old value, next read returns 8'h3C.
//   4 Write 8'h12 to 8'hEB while busy -> ignored; the in-flight byte completes unchanged and busy
//     still falls at 16*(div+1).
//   5 Write 8'h02 to 8'hE7 -> cs=2'b10; strobe held low across 5 cep pulses starts only 1 transfer.
//   6 Assert reset at bit 4 of a transfer -> next clock ck=0, busy=0, rxbuf=8'hFF; a new write works.

Source files
------------

// File: rtl/usd_spi_multi.sv
// Z80 I/O-mapped SPI master for SD/MMC cards with NCS chip selects,
// programmable SCK divider and a busy status port.
module usd_spi_multi #(
  parameter int unsigned NCS       = 2,
  parameter logic [7:0]  PORT_CS   = 8'hE7,
  parameter logic [7:0]  PORT_DATA = 8'hEB,
  parameter logic [7:0]  PORT_STAT = 8'hEF,
  parameter logic [7:0]  DIV_RST   = 8'd3
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           cep,
  input  logic           iorq,
  input  logic           wr,
  input  logic           rd,
  input  logic [7:0]     a,
  input  logic [7:0]     d,
  output logic [7:0]     q,
  output logic           busy,
  output logic [NCS-1:0] cs,
  output logic           ck,
  input  logic           miso,
  output logic           mosi
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t         state_q, state_d;
  logic [7:0]     sr_q, sr_d;
  logic [7:0]     rxbuf_q, rxbuf_d;
  logic [7:0]     div_q, div_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic           ck_q, ck_d;
  logic           rbit_q, rbit_d;
  logic [NCS-1:0] cs_q, cs_d;
  logic           iowr_prev_q, iowr_prev_d;
  logic           iord_prev_q, iord_prev_d;

  logic iowr, iord, wr_start, rd_start;

  assign iowr = !iorq && !wr;
  assign iord = !iorq && !rd;

  // Start pulses fire only on the first cep cycle a strobe is seen asserted.
  assign wr_start = cep && iowr && !iowr_prev_q && (a == PORT_DATA);
  assign rd_start = cep && iord && !iord_prev_q && (a == PORT_DATA);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      sr_q        <= 8'hFF;
      rxbuf_q     <= 8'hFF;
      div_q       <= DIV_RST;
      cnt_q       <= 8'd0;
      bitcnt_q    <= 3'd0;
      ck_q        <= 1'b0;
      rbit_q      <= 1'b0;
      cs_q        <= '1;
      iowr_prev_q <= 1'b0;
      iord_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      rxbuf_q     <= rxbuf_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      ck_q        <= ck_d;
      rbit_q      <= rbit_d;
      cs_q        <= cs_d;
      iowr_prev_q <= iowr_prev_d;
      iord_prev_q <= iord_prev_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    rxbuf_d     = rxbuf_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    bitcnt_d    = bitcnt_q;
    ck_d        = ck_q;
    rbit_d      = rbit_q;
    cs_d        = cs_q;
    iowr_prev_d = iowr_prev_q;
    iord_prev_d = iord_prev_q;

    if (cep) begin
      iowr_prev_d = iowr;
      iord_prev_d = iord;
      if (iowr && (a == PORT_CS))   cs_d  = d[NCS-1:0];
      if (iowr && (a == PORT_STAT)) div_d = d;
    end

    unique case (state_q)
      IDLE: begin
        if (wr_start || rd_start) begin
          sr_d     = wr_start ? d : 8'hFF;
          cnt_d    = div_q;
          bitcnt_d = 3'd0;
          ck_d     = 1'b0;
          state_d  = XFER;
        end
      end
      XFER: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          // Half-period tick: rising SCK samples, falling SCK shifts.
          cnt_d = div_q;
          if (!ck_q) begin
            ck_d   = 1'b1;
            rbit_d = miso;
          end else begin
            ck_d     = 1'b0;
            sr_d     = {sr_q[6:0], rbit_q};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              rxbuf_d = {sr_q[6:0], rbit_q};
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == XFER);
  assign ck   = ck_q;
  assign cs   = cs_q;
  assign mosi = sr_q[7];
  assign q    = (a == PORT_STAT) ? {busy, 7'b0} : rxbuf_q;

endmodule

// File: tb/tb_usd_spi_multi.sv
// Bench for usd_spi_multi: table vectors, spec corner sequences and random
// transfers checked against a byte-level model of an SPI exchange.
module tb_usd_spi_multi;
  localparam int NCS = 2;
  localparam int LIMIT = 16 * 256 + 40;

  logic clock = 1'b0;
  logic reset, cep, iorq, wr, rd, miso, busy, ck, mosi;
  logic [7:0] a, d, q;
  logic [NCS-1:0] cs;

  always #5 clock = ~clock;

  usd_spi_multi #(.NCS(NCS)) dut (
    .clock(clock), .reset(reset), .cep(cep), .iorq(iorq), .wr(wr), .rd(rd),
    .a(a), .d(d), .q(q), .busy(busy), .cs(cs), .ck(ck), .miso(miso), .mosi(mosi)
  );

  int errors = 0;
  int checks = 0;

  // Card side: either loops mosi back or shifts out card_byte MSB first,
  // advancing one bit after every falling SCK.
  int         rise_cnt = 0, fall_cnt = 0, fall_base = 0, busy_rises = 0;
  logic [7:0] mosi_cap = 8'h00;
  logic [7:0] card_byte = 8'hFF;
  logic       loopback = 1'b0;
  logic       busy_prev = 1'b0;
  realtime    rise_t = 0, prev_rise_t = 0;
  logic [2:0] bit_idx;

  assign bit_idx = 3'(7 - ((fall_cnt - fall_base) & 7));
  assign miso    = loopback ? mosi : card_byte[bit_idx];

  always @(posedge ck) begin
    rise_cnt    = rise_cnt + 1;
    mosi_cap    = {mosi_cap[6:0], mosi};
    prev_rise_t = rise_t;
    rise_t      = $realtime;
  end
  always @(negedge ck) fall_cnt = fall_cnt + 1;
  always @(negedge clock) begin
    if (busy && !busy_prev) busy_rises = busy_rises + 1;
    busy_prev = busy;
  end

  typedef struct {
    logic       use_wr;
    logic [7:0] div;
    logic [7:0] tx;
    logic [7:0] card;
    logic       loop;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
    int         exp_cyc;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] cur_div = 8'd3;
  logic [7:0] last_rx = 8'hFF;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: what one byte exchange must produce, from the bus-level rules.
  function automatic vec_t model(input logic use_wr, input logic [7:0] div,
                                 input logic [7:0] tx, input logic [7:0] card,
                                 input logic loop);
    vec_t v;
    logic [7:0] sent;
    sent       = use_wr ? tx : 8'hFF;
    v.use_wr   = use_wr;
    v.div      = div;
    v.tx       = tx;
    v.card     = card;
    v.loop     = loop;
    v.exp_mosi = sent;
    v.exp_rx   = loop ? sent : card;
    v.exp_cyc  = 16 * (int'(div) + 1);
    return v;
  endfunction

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    @(posedge clock); #1;
    a = addr; d = data; iorq = 1'b0; wr = 1'b0;
    @(posedge clock); #1;
    iorq = 1'b1; wr = 1'b1;
  endtask

  task automatic apply(input vec_t v, input string tag, input int inject_at);
    int cyc;
    int r0;
    logic [7:0] rdval;
    if (v.div != cur_div) begin
      bus_write(8'hEF, v.div);
      cur_div = v.div;
    end
    card_byte = v.card;
    loopback  = v.loop;
    fall_base = fall_cnt;
    r0        = rise_cnt;
    @(posedge clock); #1;
    a = 8'hEB; d = v.tx; iorq = 1'b0;
    if (v.use_wr) wr = 1'b0; else rd = 1'b0;
    #1 rdval = q;
    @(posedge clock); #1;
    iorq = 1'b1; wr = 1'b1; rd = 1'b1;
    chk({tag, "_busy_start"}, int'(busy), 1);
    cyc = 0;
    while (busy && cyc < LIMIT) begin
      if (cyc == 2) begin
        a = 8'hEF;
        #1 chk({tag, "_stat_busy"}, int'(q), 8'h80);
        a = 8'hEB;
      end
      if (cyc == inject_at) begin
        d = 8'h12; iorq = 1'b0; wr = 1'b0;
      end
      if (cyc == inject_at + 1) begin
        iorq = 1'b1; wr = 1'b1;
      end
      @(posedge clock); #1;
      cyc++;
    end
    iorq = 1'b1; wr = 1'b1;
    chk({tag, "_cycles"}, cyc, v.exp_cyc);
    chk({tag, "_sck_pulses"}, rise_cnt - r0, 8);
    chk({tag, "_mosi"}, int'(mosi_cap), int'(v.exp_mosi));
    chk({tag, "_sck_period"}, int'(rise_t - prev_rise_t), 20 * (int'(v.div) + 1));
    chk({tag, "_ck_idle"}, int'(ck), 0);
    if (!v.use_wr) chk({tag, "_read_old"}, int'(rdval), int'(last_rx));
    a = 8'h00;
    #1 chk({tag, "_rxbuf"}, int'(q), int'(v.exp_rx));
    last_rx = v.exp_rx;
  endtask

  initial begin
    int n, r0, b0;
    vec_t v;

    tbl[0] = '{1'b1, 8'd0,   8'hA5, 8'h00, 1'b1, 8'hA5, 8'hA5, 16};
    tbl[1] = '{1'b0, 8'd3,   8'h00, 8'h3C, 1'b0, 8'h3C, 8'hFF, 64};
    tbl[2] = '{1'b1, 8'd1,   8'h81, 8'h5A, 1'b0, 8'h5A, 8'h81, 32};
    tbl[3] = '{1'b1, 8'd255, 8'h0F, 8'hF0, 1'b0, 8'hF0, 8'h0F, 4096};
    tbl[4] = '{1'b0, 8'd0,   8'h00, 8'h00, 1'b0, 8'h00, 8'hFF, 16};
    tbl[5] = '{1'b1, 8'd2,   8'hFF, 8'h00, 1'b1, 8'hFF, 8'hFF, 48};

    reset = 1'b1; cep = 1'b1; iorq = 1'b1; wr = 1'b1; rd = 1'b1;
    a = 8'h00; d = 8'h00;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_cs", int'(cs), 3);
    chk("rst_ck", int'(ck), 0);
    chk("rst_mosi", int'(mosi), 1);
    chk("rst_busy", int'(busy), 0);
    a = 8'hEF;
    #1 chk("rst_stat", int'(q), 8'h00);
    a = 8'hEB;
    #1 chk("rst_data", int'(q), 8'hFF);

    for (int i = 0; i < 6; i++) apply(tbl[i], $sformatf("vec%0d", i), -10);

    // Write to the data port while busy must not disturb the exchange.
    apply(model(1'b1, 8'd2, 8'h6E, 8'h00, 1'b1), "busywr", 3);

    // Chip select write, then one strobe held across five cep pulses.
    bus_write(8'hE7, 8'h02);
    #1 chk("cs_write", int'(cs), 2);
    if (cur_div != 8'd0) begin
      bus_write(8'hEF, 8'd0);
      cur_div = 8'd0;
    end
    loopback = 1'b1;
    b0 = busy_rises;
    @(posedge clock); #1;
    cep = 1'b0; a = 8'hEB; d = 8'h55; iorq = 1'b0; wr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      repeat (9) @(posedge clock);
      #1 cep = 1'b1;
      @(posedge clock); #1 cep = 1'b0;
    end
    iorq = 1'b1; wr = 1'b1;
    repeat (3) @(posedge clock);
    #1 cep = 1'b1;
    repeat (20) @(posedge clock);
    #1 chk("held_strobe_starts", busy_rises - b0, 1);
    a = 8'h00;
    #1 chk("held_strobe_rx", int'(q), 8'h55);
    last_rx = 8'h55;

    // Reset in the middle of bit 4.
    bus_write(8'hEF, 8'd3);
    cur_div = 8'd3;
    r0 = rise_cnt;
    @(posedge clock); #1;
    a = 8'hEB; d = 8'hC3; iorq = 1'b0; wr = 1'b0;
    @(posedge clock); #1;
    iorq = 1'b1; wr = 1'b1;
    n = 0;
    while ((rise_cnt - r0) < 5 && n < 1000) begin
      @(posedge clock); #1;
      n++;
    end
    chk("mid_reach_bit4", rise_cnt - r0, 5);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("mid_rst_ck", int'(ck), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_cs", int'(cs), 3);
    a = 8'h00;
    #1 chk("mid_rst_rxbuf", int'(q), 8'hFF);
    reset = 1'b0;
    last_rx = 8'hFF;
    cur_div = 8'd3;
    apply(model(1'b1, 8'd3, 8'h96, 8'h00, 1'b1), "after_rst", -10);

    for (int i = 0; i < 8; i++) begin
      v = model(1'($urandom_range(0, 1)), 8'($urandom_range(0, 5)),
                8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      apply(v, $sformatf("rnd%0d", i), -10);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
